// File: rtl/board_pkg.sv
// Shared cell codes, neighbour ordering and reveal FSM states for the Minesweeper board memory.
package board_pkg;

    localparam logic [3:0] CELL_HIDDEN = 4'd9;
    localparam logic [3:0] CELL_MINE   = 4'd10;
    localparam logic [3:0] CELL_BOOM   = 4'd11;

    typedef enum logic [2:0] {
        NbrNW, NbrN, NbrNE, NbrW, NbrE, NbrSW, NbrS, NbrSE
    } nbr_e;

    typedef enum logic [2:0] {
        StIdle, StCenter, StScan, StWrite, StDone
    } state_e;

    function automatic logic is_mine(input logic [3:0] code);
        return (code == CELL_MINE) || (code == CELL_BOOM);
    endfunction

endpackage

// File: rtl/nbr_addr_gen.sv
// Combinational neighbour address generator: from a cell's index/row/col and a neighbour
// selector, produce the neighbour's linear index and whether it lies on the board.
module nbr_addr_gen
    import board_pkg::*;
#(
    parameter int unsigned ROWS          = 5,
    parameter int unsigned COLS          = 5,
    parameter int unsigned ADDRESS_WIDTH = 10
) (
    input  logic [ADDRESS_WIDTH-1:0] idx_i,
    input  logic [ADDRESS_WIDTH-1:0] row_i,
    input  logic [ADDRESS_WIDTH-1:0] col_i,
    input  nbr_e                     k_i,
    output logic [ADDRESS_WIDTH-1:0] nbr_idx_o,
    output logic                     in_bounds_o
);

    localparam logic [ADDRESS_WIDTH-1:0] COL_STEP = ADDRESS_WIDTH'(COLS);
    localparam logic [ADDRESS_WIDTH-1:0] ONE      = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ROW = ADDRESS_WIDTH'(ROWS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_COL = ADDRESS_WIDTH'(COLS - 1);

    logic has_n, has_s, has_w, has_e;

    assign has_n = (row_i != '0);
    assign has_s = (row_i != LAST_ROW);
    assign has_w = (col_i != '0);
    assign has_e = (col_i != LAST_COL);

    // Off-board neighbours get a wrapped address; callers must honour in_bounds_o.
    always_comb begin
        nbr_idx_o   = idx_i;
        in_bounds_o = 1'b0;
        unique case (k_i)
            NbrNW: begin nbr_idx_o = idx_i - COL_STEP - ONE; in_bounds_o = has_n && has_w; end
            NbrN:  begin nbr_idx_o = idx_i - COL_STEP;       in_bounds_o = has_n;          end
            NbrNE: begin nbr_idx_o = idx_i - COL_STEP + ONE; in_bounds_o = has_n && has_e; end
            NbrW:  begin nbr_idx_o = idx_i - ONE;            in_bounds_o = has_w;          end
            NbrE:  begin nbr_idx_o = idx_i + ONE;            in_bounds_o = has_e;          end
            NbrSW: begin nbr_idx_o = idx_i + COL_STEP - ONE; in_bounds_o = has_s && has_w; end
            NbrS:  begin nbr_idx_o = idx_i + COL_STEP;       in_bounds_o = has_s;          end
            NbrSE: begin nbr_idx_o = idx_i + COL_STEP + ONE; in_bounds_o = has_s && has_e; end
        endcase
    end

endmodule

// File: rtl/board_reveal_ram.sv
// Dual-port Minesweeper board memory: port A shared by CPU and a sequential reveal engine
// that counts neighbouring mines with one read per cycle; port B is a read-only VGA port.
module board_reveal_ram
    import board_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ROWS          = 5,
    parameter int unsigned COLS          = 5,
    parameter int unsigned ADDRESS_WIDTH = 10,
    parameter string       MEMFILE       = "dataMem.mem"
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cpu_wen_i,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0]    cpu_din_i,
    output logic [DATA_WIDTH-1:0]    cpu_dout_o,
    output logic                     wr_rej_o,
    input  logic [ADDRESS_WIDTH-1:0] vga_addr_i,
    output logic [DATA_WIDTH-1:0]    vga_dout_o,
    input  logic                     reveal_req_i,
    input  logic [ADDRESS_WIDTH-1:0] reveal_idx_i,
    output logic                     reveal_busy_o,
    output logic                     reveal_done_o,
    output logic                     reveal_mine_o,
    output logic [3:0]               reveal_count_o,
    output logic                     reveal_err_o
);

    localparam int unsigned AW     = ADDRESS_WIDTH;
    localparam int unsigned DW     = DATA_WIDTH;
    localparam int unsigned NCELLS = ROWS * COLS;

    logic [DW-1:0] mem_q [2**ADDRESS_WIDTH];
    logic [DW-1:0] a_rdata_q, vga_dout_q, cpu_hold_q;

    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;

    state_e        state_q, state_d;
    logic [3:0]    k_q, k_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d, row_q, row_d, col_q, col_d;
    logic          oob_q, oob_d;
    logic          nbr_vld_q, nbr_vld_d;
    logic          done_q, done_d, mine_q, mine_d, err_q, err_d;
    logic [3:0]    count_q, count_d;
    logic          wr_rej_q, wr_rej_d;
    logic          cpu_rd_q, cpu_rd_d;

    logic [AW-1:0] row_calc, col_calc;
    logic          idx_ok;
    logic [AW-1:0] nbr_idx;
    logic          nbr_in_bounds;
    nbr_e          nbr_k;
    logic [3:0]    code;

    // Read-first port A; the write and read of the same edge see the old contents.
    always_ff @(posedge clk_i) begin
        if (a_we) begin
            mem_q[a_addr] <= a_wdata;
        end
        a_rdata_q <= mem_q[a_addr];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vga_dout_q <= '0;
        end else begin
            vga_dout_q <= mem_q[vga_addr_i];
        end
    end

    // Row/col by comparator chain so no divider is needed; latched once per reveal.
    always_comb begin
        row_calc = '0;
        for (int unsigned r = 1; r < ROWS; r++) begin
            if (32'(reveal_idx_i) >= r * COLS) begin
                row_calc = AW'(r);
            end
        end
        col_calc = reveal_idx_i - AW'(32'(row_calc) * COLS);
    end

    assign idx_ok = (32'(reveal_idx_i) < NCELLS);
    assign nbr_k  = nbr_e'(k_q[2:0]);
    assign code   = a_rdata_q[3:0];

    nbr_addr_gen #(
        .ROWS          (ROWS),
        .COLS          (COLS),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_nbr_addr_gen (
        .idx_i       (idx_q),
        .row_i       (row_q),
        .col_i       (col_q),
        .k_i         (nbr_k),
        .nbr_idx_o   (nbr_idx),
        .in_bounds_o (nbr_in_bounds)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        row_d     = row_q;
        col_d     = col_q;
        oob_d     = oob_q;
        nbr_vld_d = 1'b0;
        done_d    = 1'b0;
        mine_d    = mine_q;
        count_d   = count_q;
        err_d     = err_q;
        cpu_rd_d  = 1'b0;
        wr_rej_d  = cpu_wen_i && ((state_q != StIdle) || reveal_req_i);
        a_we      = 1'b0;
        a_addr    = cpu_addr_i;
        a_wdata   = cpu_din_i;

        unique case (state_q)
            StIdle: begin
                if (reveal_req_i) begin
                    idx_d   = reveal_idx_i;
                    row_d   = row_calc;
                    col_d   = col_calc;
                    oob_d   = !idx_ok;
                    cnt_d   = '0;
                    k_d     = '0;
                    a_addr  = reveal_idx_i;
                    state_d = idx_ok ? StCenter : StDone;
                end else begin
                    a_we     = cpu_wen_i;
                    cpu_rd_d = 1'b1;
                end
            end
            StCenter: begin
                // Speculatively read the first neighbour while the centre code is decoded.
                a_addr = nbr_idx;
                if (code == CELL_HIDDEN) begin
                    nbr_vld_d = nbr_in_bounds;
                    k_d       = 4'd1;
                    state_d   = StScan;
                end else if (code == CELL_MINE) begin
                    a_we    = 1'b1;
                    a_addr  = idx_q;
                    a_wdata = DW'(CELL_BOOM);
                    cnt_d   = CELL_BOOM;
                    state_d = StDone;
                end else begin
                    cnt_d   = code;
                    state_d = StDone;
                end
            end
            StScan: begin
                a_addr    = nbr_idx;
                nbr_vld_d = nbr_in_bounds && (k_q != 4'd8);
                if (nbr_vld_q && is_mine(code)) begin
                    cnt_d = cnt_q + 4'd1;
                end
                if (k_q == 4'd8) begin
                    k_d     = '0;
                    state_d = StWrite;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            StWrite: begin
                a_we    = 1'b1;
                a_addr  = idx_q;
                a_wdata = DW'(cnt_q);
                state_d = StDone;
            end
            StDone: begin
                done_d  = 1'b1;
                err_d   = oob_q;
                count_d = oob_q ? 4'd0 : cnt_q;
                mine_d  = !oob_q && (cnt_q == CELL_BOOM);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            k_q        <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            oob_q      <= 1'b0;
            nbr_vld_q  <= 1'b0;
            done_q     <= 1'b0;
            mine_q     <= 1'b0;
            count_q    <= '0;
            err_q      <= 1'b0;
            wr_rej_q   <= 1'b0;
            cpu_rd_q   <= 1'b0;
            cpu_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            oob_q      <= oob_d;
            nbr_vld_q  <= nbr_vld_d;
            done_q     <= done_d;
            mine_q     <= mine_d;
            count_q    <= count_d;
            err_q      <= err_d;
            wr_rej_q   <= wr_rej_d;
            cpu_rd_q   <= cpu_rd_d;
            cpu_hold_q <= cpu_dout_o;
        end
    end

    // CPU data only refreshes on edges where the CPU owned port A; otherwise it holds.
    assign cpu_dout_o     = cpu_rd_q ? a_rdata_q : cpu_hold_q;
    assign wr_rej_o       = wr_rej_q;
    assign vga_dout_o     = vga_dout_q;
    assign reveal_busy_o  = (state_q != StIdle);
    assign reveal_done_o  = done_q;
    assign reveal_mine_o  = mine_q;
    assign reveal_count_o = count_q;
    assign reveal_err_o   = err_q;

endmodule

// File: tb/tb_board_reveal_ram.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and randomized
// boards checked against a cell-rule reference model; a second 8x16 instance for scaling.
module tb_board_reveal_ram;

    localparam int DW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cpu_wen, wr_rej, req, busy, done, mine, err;
    logic [AW-1:0] cpu_addr, vga_addr, ridx;
    logic [DW-1:0] cpu_din, cpu_dout, vga_dout;
    logic [3:0]    count;

    logic          cpu_wen2, wr_rej2, req2, busy2, done2, mine2, err2;
    logic [AW-1:0] cpu_addr2, vga_addr2, ridx2;
    logic [DW-1:0] cpu_din2, cpu_dout2, vga_dout2;
    logic [3:0]    count2;

    board_reveal_ram #(.DATA_WIDTH(DW), .ROWS(5), .COLS(5), .ADDRESS_WIDTH(AW), .MEMFILE("")) dut (
        .clk_i(clk), .rst_ni(rst_n), .cpu_wen_i(cpu_wen), .cpu_addr_i(cpu_addr),
        .cpu_din_i(cpu_din), .cpu_dout_o(cpu_dout), .wr_rej_o(wr_rej), .vga_addr_i(vga_addr),
        .vga_dout_o(vga_dout), .reveal_req_i(req), .reveal_idx_i(ridx), .reveal_busy_o(busy),
        .reveal_done_o(done), .reveal_mine_o(mine), .reveal_count_o(count), .reveal_err_o(err)
    );

    board_reveal_ram #(.DATA_WIDTH(DW), .ROWS(8), .COLS(16), .ADDRESS_WIDTH(AW), .MEMFILE("")) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .cpu_wen_i(cpu_wen2), .cpu_addr_i(cpu_addr2),
        .cpu_din_i(cpu_din2), .cpu_dout_o(cpu_dout2), .wr_rej_o(wr_rej2), .vga_addr_i(vga_addr2),
        .vga_dout_o(vga_dout2), .reveal_req_i(req2), .reveal_idx_i(ridx2), .reveal_busy_o(busy2),
        .reveal_done_o(done2), .reveal_mine_o(mine2), .reveal_count_o(count2), .reveal_err_o(err2)
    );

    int n_checks = 0;
    int n_errors = 0;
    int board[25];

    typedef struct {
        int idx;
        int mask;
        int exp_count;
        int exp_mine;
        int exp_err;
        int exp_lat;
        int exp_cell;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input int a, input int d);
        cpu_wen  = 1'b1;
        cpu_addr = AW'(a);
        cpu_din  = DW'(d);
        step();
        cpu_wen  = 1'b0;
    endtask

    task automatic load_board();
        for (int i = 0; i < 25; i++) cpu_write(i, board[i]);
    endtask

    task automatic vga_peek(input int a, output int d);
        vga_addr = AW'(a);
        step();
        d = int'(vga_dout);
    endtask

    task automatic run_reveal(input int idx, input bit with_wen,
                              output int lat, output int c, output int m, output int e);
        req  = 1'b1;
        ridx = AW'(idx);
        if (with_wen) begin
            cpu_wen  = 1'b1;
            cpu_addr = AW'(2);
            cpu_din  = '0;
        end
        step();
        req     = 1'b0;
        cpu_wen = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        if (with_wen) check("wr_rej_on_accept", int'(wr_rej), 1);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (done) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 0, 1);
        c = int'(count);
        m = int'(mine);
        e = int'(err);
        check("busy_clear_at_done", int'(busy), 0);
    endtask

    // Reference: applies the reveal rules directly to the board array.
    task automatic model_reveal(input int idx, output int lat, output int c,
                                output int m, output int e);
        c = 0; m = 0; e = 0;
        if (idx >= 25) begin
            e = 1;
            lat = 1;
            return;
        end
        if (board[idx] == 9) begin
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    int r, cc;
                    r  = idx / 5 + dr;
                    cc = idx % 5 + dc;
                    if ((dr != 0 || dc != 0) && r >= 0 && r < 5 && cc >= 0 && cc < 5)
                        if (board[r * 5 + cc] == 10 || board[r * 5 + cc] == 11) c++;
                end
            end
            board[idx] = c;
            lat = 11;
        end else if (board[idx] == 10) begin
            board[idx] = 11;
            c = 11; m = 1; lat = 2;
        end else begin
            c = board[idx];
            m = (c == 11) ? 1 : 0;
            lat = 2;
        end
    endtask

    initial begin
        int lat, c, m, e, d, ndone, first_lat, first_cnt;
        int elat, ec, em, ee;

        cpu_wen = 0; cpu_addr = '0; cpu_din = '0; vga_addr = '0; req = 0; ridx = '0;
        cpu_wen2 = 0; cpu_addr2 = '0; cpu_din2 = '0; vga_addr2 = '0; req2 = 0; ridx2 = '0;

        vecs[0] = '{12, (1 << 6) | (1 << 8) | (1 << 16), 3, 0, 0, 11, 3};
        vecs[1] = '{0, (1 << 1) | (1 << 5) | (1 << 6), 3, 0, 0, 11, 3};
        vecs[2] = '{4, (1 << 5), 0, 0, 0, 11, 0};
        vecs[3] = '{7, (1 << 7), 11, 1, 0, 2, 11};
        vecs[4] = '{25, 0, 0, 0, 1, 1, -1};
        vecs[5] = '{24, (1 << 18) | (1 << 19) | (1 << 23) | 1, 3, 0, 0, 11, 3};
        vecs[6] = '{10, (1 << 4) | (1 << 9) | (1 << 14) | (1 << 5), 1, 0, 0, 11, 1};

        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_count", int'(count), 0);
        check("rst_mine", int'(mine), 0);
        check("rst_err", int'(err), 0);
        check("rst_wr_rej", int'(wr_rej), 0);
        check("rst_cpu_dout", int'(cpu_dout), 0);
        check("rst_vga_dout", int'(vga_dout), 0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 25; i++) board[i] = vecs[v].mask[i] ? 10 : 9;
            load_board();
            run_reveal(vecs[v].idx, 1'b0, lat, c, m, e);
            check($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
            check($sformatf("vec%0d_err", v), e, vecs[v].exp_err);
            if (vecs[v].exp_err == 0) begin
                check($sformatf("vec%0d_count", v), c, vecs[v].exp_count);
                check($sformatf("vec%0d_mine", v), m, vecs[v].exp_mine);
                vga_peek(vecs[v].idx, d);
                check($sformatf("vec%0d_cell", v), d, vecs[v].exp_cell);
            end
        end

        // CPU write and a second request during SCAN: write dropped, request ignored.
        for (int i = 0; i < 25; i++) board[i] = 9;
        board[6] = 10;
        load_board();
        req = 1'b1; ridx = AW'(12);
        step();
        req = 1'b0;
        step(); step(); step();
        cpu_wen = 1'b1; cpu_addr = AW'(3); cpu_din = 32'h55; req = 1'b1; ridx = '0;
        step();
        cpu_wen = 1'b0; req = 1'b0;
        check("wr_rej_scan", int'(wr_rej), 1);
        ndone = 0; first_lat = -1; first_cnt = -1;
        for (int n = 5; n <= 25; n++) begin
            step();
            if (n == 5) check("wr_rej_one_cycle", int'(wr_rej), 0);
            if (done) begin
                ndone++;
                if (first_lat < 0) begin
                    first_lat = n;
                    first_cnt = int'(count);
                end
            end
        end
        check("scan_single_done", ndone, 1);
        check("scan_done_lat", first_lat, 11);
        check("scan_count", first_cnt, 1);
        vga_peek(3, d);
        check("scan_rejected_write", d, 9);
        vga_peek(12, d);
        check("scan_cell", d, 1);

        // CPU port: read-first write, plain read, and hold on the acceptance edge.
        cpu_wen = 1'b1; cpu_addr = AW'(20); cpu_din = 32'd7;
        step();
        cpu_wen = 1'b0;
        check("cpu_read_first", int'(cpu_dout), 9);
        step();
        check("cpu_read_new", int'(cpu_dout), 7);
        cpu_addr = AW'(12);
        step();
        check("cpu_read_cell", int'(cpu_dout), 1);
        cpu_addr = AW'(20);
        run_reveal(0, 1'b0, lat, c, m, e);
        check("cpu_hold_busy", int'(cpu_dout), 1);
        check("corner_nbr_count", c, 1);

        // Mine reveal with a CPU write on the acceptance edge, then re-reveal of BOOM.
        for (int i = 0; i < 25; i++) board[i] = 9;
        board[7] = 10;
        load_board();
        run_reveal(7, 1'b1, lat, c, m, e);
        check("boom_lat", lat, 2);
        check("boom_count", c, 11);
        check("boom_mine", m, 1);
        vga_peek(2, d);
        check("accept_write_dropped", d, 9);
        run_reveal(7, 1'b0, lat, c, m, e);
        check("rereveal_lat", lat, 2);
        check("rereveal_count", c, 11);
        check("rereveal_mine", m, 1);
        vga_peek(7, d);
        check("rereveal_cell", d, 11);

        // Randomized boards against the reference model.
        for (int it = 0; it < 40; it++) begin
            int idx, r;
            for (int i = 0; i < 25; i++) begin
                r = int'($urandom_range(0, 9));
                if (r < 5) board[i] = 9;
                else if (r < 8) board[i] = 10;
                else if (r == 8) board[i] = 11;
                else board[i] = int'($urandom_range(0, 8));
            end
            load_board();
            idx = int'($urandom_range(0, 27));
            model_reveal(idx, elat, ec, em, ee);
            run_reveal(idx, 1'b0, lat, c, m, e);
            check($sformatf("rnd%0d_lat", it), lat, elat);
            check($sformatf("rnd%0d_err", it), e, ee);
            if (ee == 0) begin
                check($sformatf("rnd%0d_count", it), c, ec);
                check($sformatf("rnd%0d_mine", it), m, em);
                vga_peek(idx, d);
                check($sformatf("rnd%0d_cell", it), d, board[idx]);
            end
        end

        // 8x16 board, interior cell 87 (row 5, col 7).
        for (int i = 0; i < 128; i++) begin
            cpu_wen2 = 1'b1; cpu_addr2 = AW'(i);
            cpu_din2 = (i == 71 || i == 86 || i == 104 || i == 89) ? 32'd10 : 32'd9;
            step();
        end
        cpu_wen2 = 1'b0;
        req2 = 1'b1; ridx2 = AW'(87);
        step();
        req2 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (done2) begin
                lat = n;
                break;
            end
        end
        check("big_lat", lat, 11);
        check("big_count", int'(count2), 3);
        check("big_err", int'(err2), 0);
        vga_addr2 = AW'(87);
        step();
        check("big_cell", int'(vga_dout2), 3);

        // Asynchronous reset in the middle of a scan.
        for (int i = 0; i < 25; i++) board[i] = 9;
        load_board();
        req = 1'b1; ridx = AW'(12);
        step();
        req = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_count", int'(count), 0);
        check("midrst_mine", int'(mine), 0);
        check("midrst_err", int'(err), 0);
        check("midrst_cpu_dout", int'(cpu_dout), 0);
        check("midrst_vga_dout", int'(vga_dout), 0);
        step();
        rst_n = 1'b1;
        vga_peek(12, d);
        check("midrst_cell_untouched", d, 9);
        run_reveal(12, 1'b0, lat, c, m, e);
        check("postrst_lat", lat, 11);
        check("postrst_count", c, 0);
        vga_peek(12, d);
        check("postrst_cell", d, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
